ocp_slave_fsm: RTL and testbench

OCP 2.2 slave-side controller, the responder counterpart to ocp_master_fsm on the same Basic/Simple/Burst signal set. It accepts WR and RD requests, including incrementing precise bursts issued one request per beat, and drives SCmdAccept, SResp, SData and SRespLast. It also drives a synchronous local memory port toward the bridge-side backend and tracks burst beats against MBurstLength and MReqLast.

---
 rtl/ocp_slave_fsm.sv | 148 ++++++++++++++
 tb/tb_ocp_slave_fsm.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_slave_fsm.sv
// OCP 2.2 slave controller: WR/RD singles and incrementing precise bursts onto a synchronous backend port.
// Optional macro OCP_SLAVE_WRITE_RESP_EN: accepted writes return DVA instead of being posted.
module ocp_slave_fsm #(
    parameter int unsigned MDATA_WIDTH    = 8,
    parameter int unsigned MADDR_WIDTH    = 64,
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned ADDR_SHIFT     = 2
) (
    input  logic                      Clk,
    input  logic                      reset_n,
    input  logic [2:0]                MCmd,
    input  logic [MADDR_WIDTH-1:0]    MAddr,
    input  logic [MDATA_WIDTH-1:0]    MData,
    input  logic [9:0]                MBurstLength,
    input  logic                      MReqLast,
    output logic                      SCmdAccept,
    output logic [1:0]                SResp,
    output logic [MDATA_WIDTH-1:0]    SData,
    output logic                      SRespLast,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_wr_en,
    output logic [MDATA_WIDTH-1:0]    mem_wdata,
    output logic                      mem_rd_en,
    input  logic [MDATA_WIDTH-1:0]    mem_rdata,
    input  logic                      mem_ready,
    output logic                      burst_err
);
    localparam int unsigned WORD_TOP = MEM_ADDR_WIDTH + ADDR_SHIFT;
    localparam int unsigned LEN_W    = 10;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_WR    = 3'b001;
    localparam logic [2:0] CMD_RD    = 3'b010;
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST_WR,
        S_BURST_RD
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       resp_d;
    logic             last_d;
    logic             rd_q, rd_d;
    logic             err_d;

    logic addr_oor;
    logic cmd_ok;
    logic in_burst;
    logic same_cmd;
    logic exec_ok;
    logic final_beat;
    logic unused_addr_lsbs;

    // Any address bit above the backend word field makes the request unserviceable
    generate
        if (MADDR_WIDTH > WORD_TOP) begin : g_oor
            assign addr_oor = |MAddr[MADDR_WIDTH-1:WORD_TOP];
        end else begin : g_no_oor
            assign addr_oor = 1'b0;
        end
    endgenerate

    assign unused_addr_lsbs = ^MAddr[ADDR_SHIFT-1:0];

    assign cmd_ok   = (MCmd == CMD_WR) || (MCmd == CMD_RD);
    assign in_burst = (state_q != S_IDLE);
    assign same_cmd = ((state_q == S_BURST_WR) && (MCmd == CMD_WR)) ||
                      ((state_q == S_BURST_RD) && (MCmd == CMD_RD));
    assign exec_ok  = cmd_ok && !addr_oor && (!in_burst || same_cmd);

    // Requests that never touch the backend are taken without waiting on mem_ready
    assign SCmdAccept = (MCmd != CMD_IDLE) && (mem_ready || !exec_ok);
    assign final_beat = in_burst ? (cnt_q == LEN_W'(1)) : (MBurstLength <= LEN_W'(1));

    assign mem_addr  = MAddr[WORD_TOP-1:ADDR_SHIFT];
    assign mem_wdata = MData;
    assign mem_wr_en = SCmdAccept && exec_ok && (MCmd == CMD_WR);
    assign mem_rd_en = SCmdAccept && exec_ok && (MCmd == CMD_RD);

    // Backend data arrives in the response cycle, so it is steered straight out
    assign SData = rd_q ? mem_rdata : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = RESP_NULL;
        last_d  = 1'b0;
        rd_d    = 1'b0;
        err_d   = burst_err;

        if (SCmdAccept) begin
            if (!exec_ok) begin
                resp_d  = RESP_ERR;
                last_d  = 1'b1;
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                if (MReqLast != final_beat) begin
                    err_d = 1'b1;
                end
                if (in_burst) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end else if (!final_beat) begin
                    cnt_d   = MBurstLength - LEN_W'(1);
                    state_d = (MCmd == CMD_WR) ? S_BURST_WR : S_BURST_RD;
                end
                if (MCmd == CMD_RD) begin
                    resp_d = RESP_DVA;
                    last_d = final_beat;
                    rd_d   = 1'b1;
                end
`ifdef OCP_SLAVE_WRITE_RESP_EN
                else begin
                    resp_d = RESP_DVA;
                    last_d = final_beat;
                end
`endif
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            SResp     <= RESP_NULL;
            SRespLast <= 1'b0;
            rd_q      <= 1'b0;
            burst_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            SResp     <= resp_d;
            SRespLast <= last_d;
            rd_q      <= rd_d;
            burst_err <= err_d;
        end
    end

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// Bench for ocp_slave_fsm: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_ocp_slave_fsm;
    logic        Clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  MCmd = 3'b000;
    logic [63:0] MAddr = '0;
    logic [7:0]  MData = '0;
    logic [9:0]  MBurstLength = '0;
    logic        MReqLast = 1'b0;
    logic        SCmdAccept;
    logic [1:0]  SResp;
    logic [7:0]  SData;
    logic        SRespLast;
    logic [9:0]  mem_addr;
    logic        mem_wr_en;
    logic [7:0]  mem_wdata;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 1'b1;
    logic        burst_err;

    ocp_slave_fsm dut (
        .Clk(Clk), .reset_n(reset_n), .MCmd(MCmd), .MAddr(MAddr), .MData(MData),
        .MBurstLength(MBurstLength), .MReqLast(MReqLast), .SCmdAccept(SCmdAccept),
        .SResp(SResp), .SData(SData), .SRespLast(SRespLast), .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .burst_err(burst_err)
    );

    always #5 Clk = ~Clk;

    // Backend stub: synchronous memory, filled with a known pattern on the first edge
    logic [7:0] bk_mem [0:1023];
    bit         bk_init = 1'b0;
    always @(posedge Clk) begin
        if (!bk_init) begin
            for (int i = 0; i < 1024; i++) bk_mem[i] <= 8'(i * 7 + 3);
            bk_init <= 1'b1;
        end else begin
            if (mem_wr_en) bk_mem[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= bk_mem[mem_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: memory image, open burst (command + beats still owed), pending response
    logic [7:0] ref_mem [0:1023];
    logic [2:0] m_cmd = 3'b000;
    int         m_left = 0;
    logic       m_err = 1'b0;
    logic [1:0] exp_resp = 2'b00;
    logic       exp_last = 1'b0;
    logic [7:0] exp_data = '0;

    int         stall_n = 0;
    bit         rnd_rdy = 1'b0;
    logic       s_acc;
    logic [8:0] rd_seen [$];
    logic [8:0] burst_exp [4] = '{9'h004, 9'h008, 9'h00C, 9'h120};

    function automatic logic executable(input logic [2:0] cmd, input logic [63:0] addr);
        if (cmd != 3'b001 && cmd != 3'b010) return 1'b0;
        if ((addr >> 12) != 64'd0) return 1'b0;
        if (m_cmd != 3'b000 && cmd != m_cmd) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_cmd = 3'b000; m_left = 0; m_err = 1'b0;
        exp_resp = 2'b00; exp_last = 1'b0; exp_data = '0;
    endtask

    task automatic model_step(input logic acc, input logic exec);
        logic fin;
        int   word;
        exp_resp = 2'b00; exp_last = 1'b0; exp_data = '0;
        if (!acc) return;
        if (!exec) begin
            exp_resp = 2'b11; exp_last = 1'b1; m_cmd = 3'b000; m_left = 0;
            return;
        end
        if (m_cmd == 3'b000) begin
            m_left = (MBurstLength == 10'd0) ? 0 : int'(MBurstLength) - 1;
            if (m_left > 0) m_cmd = MCmd;
        end else begin
            m_left--;
            if (m_left == 0) m_cmd = 3'b000;
        end
        fin  = (m_left == 0);
        if (MReqLast != fin) m_err = 1'b1;
        word = int'(MAddr >> 2);
        if (MCmd == 3'b010) begin
            exp_resp = 2'b01; exp_last = fin; exp_data = ref_mem[word];
        end else begin
            ref_mem[word] = MData;
`ifdef OCP_SLAVE_WRITE_RESP_EN
            exp_resp = 2'b01; exp_last = fin;
`endif
        end
    endtask

    // One clock: entered at a falling edge with the request already driven
    task automatic cycle();
        logic e_exec, e_acc;
        if (stall_n > 0) begin
            mem_ready = 1'b0;
            stall_n--;
        end else begin
            mem_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        #4;
        e_exec = executable(MCmd, MAddr);
        e_acc  = (MCmd != 3'b000) && (mem_ready || !e_exec);
        check("SCmdAccept", 64'(SCmdAccept), 64'(e_acc));
        check("mem_wr_en", 64'(mem_wr_en), 64'(e_acc && e_exec && MCmd == 3'b001));
        check("mem_rd_en", 64'(mem_rd_en), 64'(e_acc && e_exec && MCmd == 3'b010));
        if (e_acc && e_exec) check("mem_addr", 64'(mem_addr), MAddr >> 2);
        if (e_acc && e_exec && MCmd == 3'b001) check("mem_wdata", 64'(mem_wdata), 64'(MData));
        check("SResp", 64'(SResp), 64'(exp_resp));
        check("SRespLast", 64'(SRespLast), 64'(exp_last));
        check("SData", 64'(SData), 64'(exp_data));
        check("burst_err", 64'(burst_err), 64'(m_err));
        s_acc = SCmdAccept;
        if (SResp == 2'b01) rd_seen.push_back({SRespLast, SData});
        @(posedge Clk);
        model_step(e_acc, e_exec);
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        MCmd = 3'b000;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic beat(input logic [2:0] cmd, input logic [63:0] addr, input logic [7:0] data,
                        input logic [9:0] len, input logic last);
        MCmd = cmd; MAddr = addr; MData = data; MBurstLength = len; MReqLast = last;
        s_acc = 1'b0;
        for (int i = 0; i < 64 && !s_acc; i++) cycle();
        check("accept_within_bound", 64'(s_acc), 64'd1);
        MCmd = 3'b000;
    endtask

    task automatic hard_reset();
        MCmd = 3'b000;
        #1 reset_n = 1'b0;
        #1;
        check("rst_SResp", 64'(SResp), 64'd0);
        check("rst_SRespLast", 64'(SRespLast), 64'd0);
        check("rst_SData", 64'(SData), 64'd0);
        check("rst_burst_err", 64'(burst_err), 64'd0);
        check("rst_SCmdAccept", 64'(SCmdAccept), 64'd0);
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [63:0] word_addr(input int w);
        return 64'(w) * 64'd4 + 64'($urandom_range(0, 3));
    endfunction

    function automatic logic [63:0] oor_addr();
        return (64'd1 << $urandom_range(12, 63)) | 64'($urandom_range(0, 4095));
    endfunction

    // Sends the first `sent` beats of an n-beat burst; beat index `bad` gets the wrong MReqLast
    task automatic burst(input logic [2:0] cmd, input int word, input int n, input int bad,
                         input int sent, input bit gaps);
        logic [9:0] len;
        for (int b = 0; b < sent; b++) begin
            len = (b == 0) ? 10'(n) : 10'($urandom_range(0, 1023));
            beat(cmd, word_addr(word + b), 8'($urandom), len, (b == n - 1) ^ (b == bad));
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);
        hard_reset();

        // Single posted write, then read it back
        beat(3'b001, 64'h4, 8'hFF, 10'd1, 1'b1);
        idle(1);
        check("wr_backend_word1", 64'(bk_mem[1]), 64'hFF);
        rd_seen.delete();
        beat(3'b010, 64'h4, 8'h00, 10'd1, 1'b1);
        idle(1);
        check("single_rd_count", 64'(rd_seen.size()), 64'd1);
        if (rd_seen.size() > 0) check("single_rd_resp", 64'(rd_seen[0]), 64'h1FF);

        // Preload words 0..3 through a write burst, then stalled read burst
        beat(3'b001, 64'h0, 8'h04, 10'd4, 1'b0);
        beat(3'b001, 64'h4, 8'h08, 10'd4, 1'b0);
        beat(3'b001, 64'h8, 8'h0C, 10'd4, 1'b0);
        beat(3'b001, 64'hC, 8'h20, 10'd4, 1'b1);
        idle(1);
        rd_seen.delete();
        stall_n = 3;
        burst(3'b010, 0, 4, -1, 4, 1'b0);
        idle(2);
        check("rd_burst_count", 64'(rd_seen.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < rd_seen.size()) check("rd_burst_beat", 64'(rd_seen[i]), 64'(burst_exp[i]));

        // Write burst with early MReqLast: error flagged, all four beats still written
        beat(3'b001, 64'h40, 8'h11, 10'd4, 1'b0);
        beat(3'b001, 64'h44, 8'h22, 10'd4, 1'b1);
        beat(3'b001, 64'h48, 8'h33, 10'd4, 1'b0);
        beat(3'b001, 64'h4C, 8'h44, 10'd4, 1'b1);
        idle(1);
        check("mreqlast_burst_err", 64'(burst_err), 64'd1);
        check("wr_burst_last_word", 64'(bk_mem[19]), 64'h44);
        rd_seen.delete();
        beat(3'b010, 64'h44, 8'h00, 10'd1, 1'b1);
        idle(1);
        check("idle_after_burst_rd", 64'(rd_seen.size() > 0 ? rd_seen[0] : 9'h0), 64'h122);

        // Unsupported command, then a read breaking a write burst
        beat(3'b011, 64'h0, 8'h00, 10'd1, 1'b1);
        idle(1);
        beat(3'b001, 64'h80, 8'h5A, 10'd3, 1'b0);
        beat(3'b010, 64'h84, 8'h00, 10'd1, 1'b1);
        idle(1);
        beat(3'b010, 64'h80, 8'h00, 10'd1, 1'b1);
        idle(1);

        // Reset in the middle of a read burst, then a clean single read
        beat(3'b010, 64'h0, 8'h00, 10'd4, 1'b0);
        beat(3'b010, 64'h4, 8'h00, 10'd4, 1'b0);
        hard_reset();
        beat(3'b010, 64'h8, 8'h00, 10'd1, 1'b1);
        idle(2);

        // Randomized traffic with random backend back-pressure
        rnd_rdy = 1'b1;
        for (int t = 0; t < 300; t++) begin
            int kind, n, k, w;
            logic [2:0] c;
            kind = $urandom_range(0, 19);
            c    = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
            n    = $urandom_range(2, 6);
            w    = $urandom_range(0, 1023 - n);
            if (kind < 5) begin
                beat(c, word_addr(w), 8'($urandom), 10'($urandom_range(0, 1)), 1'b1);
            end else if (kind < 11) begin
                burst(c, w, n, ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1, n, 1'b1);
            end else if (kind < 13) begin
                beat(3'($urandom_range(3, 7)), word_addr(w), 8'($urandom), 10'd1, 1'b1);
            end else if (kind < 15) begin
                beat(c, oor_addr(), 8'($urandom), 10'($urandom_range(0, 4)), 1'b1);
            end else if (kind < 19) begin
                k = $urandom_range(1, n - 1);
                burst(c, w, n, -1, k, 1'b1);
                case ($urandom_range(0, 2))
                    0: beat(c ^ 3'b011, word_addr(w), 8'($urandom), 10'd1, 1'b1);
                    1: beat(3'($urandom_range(3, 7)), word_addr(w), 8'($urandom), 10'd1, 1'b1);
                    default: beat(c, oor_addr(), 8'($urandom), 10'd1, 1'b0);
                endcase
            end else begin
                burst(c, w, n, -1, $urandom_range(1, n - 1), 1'b0);
                hard_reset();
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
